// File: rtl/aplausos_tx.sv
// Clap-pattern transmitter: emits a single or double clap pulse train, then holds off
// long enough for the downstream clap detector's window to close before going idle.
module aplausos_tx #(
    parameter int PULSE_CYC   = 2_500_000,
    parameter int GAP_CYC     = 15_000_000,
    parameter int HOLDOFF_CYC = 110_000_000,
    parameter int CNT_W       = 27
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic num_claps,
    output logic ready,
    output logic busy,
    output logic clap_out,
    output logic done
);

    typedef enum logic [2:0] {IDLE, PULSE1, GAP, PULSE2, HOLDOFF} state_t;

    localparam logic [CNT_W-1:0] PULSE_TC = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_TC   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLDOFF_CYC - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             dbl, dbl_nxt;
    logic             clap_nxt, done_nxt;
    logic             tc;

    // One shared counter; terminal count depends on which timed phase we are in.
    always_comb begin
        tc = 1'b0;
        case (state)
            PULSE1, PULSE2: tc = (cnt == PULSE_TC);
            GAP:            tc = (cnt == GAP_TC);
            HOLDOFF:        tc = (cnt == HOLD_TC);
            default:        tc = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dbl      <= 1'b0;
            clap_out <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dbl      <= dbl_nxt;
            clap_out <= clap_nxt;
            done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = PULSE1;
            PULSE1:  if (tc)    state_nxt = dbl ? GAP : HOLDOFF;
            GAP:     if (tc)    state_nxt = PULSE2;
            PULSE2:  if (tc)    state_nxt = HOLDOFF;
            HOLDOFF: if (tc)    state_nxt = IDLE;
            default:            state_nxt = IDLE;
        endcase
    end

    // clap_out is registered from the next state so it lines up with the phase exactly.
    always_comb begin
        cnt_nxt  = (state == IDLE || tc) ? '0 : cnt + CNT_W'(1);
        dbl_nxt  = (state == IDLE && start) ? num_claps : dbl;
        clap_nxt = (state_nxt == PULSE1) || (state_nxt == PULSE2);
        done_nxt = (state == HOLDOFF) && tc;
        ready    = (state == IDLE);
        busy     = (state != IDLE);
    end

endmodule

// File: tb/tb_aplausos_tx.sv
// Bench for aplausos_tx with short timing: a pattern-level model checked every cycle,
// plus literal waveform points for the single, double, ignored-start, reset and back-to-back cases.
module tb_aplausos_tx;

    localparam int P = 4;
    localparam int G = 6;
    localparam int H = 10;

    logic clk = 1'b0;
    logic rst_n, start, num_claps;
    logic ready, busy, clap_out, done;

    int vectors = 0;
    int miscompares = 0;

    aplausos_tx #(.PULSE_CYC(P), .GAP_CYC(G), .HOLDOFF_CYC(H), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_claps(num_claps),
        .ready(ready), .busy(busy), .clap_out(clap_out), .done(done)
    );

    always #5 clk = ~clk;

    // Model: a pattern is described by its accept edge and type; outputs follow from the offset.
    int   cyc = 0;
    bit   armed = 1'b0;
    bit   m_act = 1'b0;
    bit   m_dbl = 1'b0;
    int   m_s = 0;

    function automatic int pat_end(input bit d);
        return d ? (2*P + G + H) : (P + H);
    endfunction

    function automatic bit m_busy_at(input int c);
        int t;
        t = c - m_s;
        return m_act && t >= 1 && t <= pat_end(m_dbl);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_act <= 1'b0;
        end else if (!m_busy_at(cyc) && start) begin
            m_act <= 1'b1;
            m_s   <= cyc;
            m_dbl <= num_claps;
        end
        cyc   <= cyc + 1;
        armed <= 1'b1;
    end

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            int t;
            bit e_clap, e_busy, e_done;
            t      = cyc - m_s;
            e_clap = m_act && ((t >= 1 && t <= P) ||
                               (m_dbl && t >= P + G + 1 && t <= 2*P + G));
            e_busy = m_busy_at(cyc);
            e_done = m_act && (t == pat_end(m_dbl) + 1);
            chk("model clap_out", clap_out, e_clap);
            chk("model busy", busy, e_busy);
            chk("model ready", ready, !e_busy);
            chk("model done", done, e_done);
        end
    end

    int k;

    task automatic wait_to(input int n);
        while (cyc < k + n) @(negedge clk);
    endtask

    task automatic launch(input bit d);
        @(negedge clk);
        start     = 1'b1;
        num_claps = d;
        k         = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num_claps = 1'b0; k = 0;
        repeat (3) @(negedge clk);
        chk("reset ready", ready, 1'b1);
        chk("reset busy", busy, 1'b0);
        chk("reset clap_out", clap_out, 1'b0);
        chk("reset done", done, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single clap
        launch(1'b0);
        wait_to(1);  chk("single clap c1", clap_out, 1'b1);
        wait_to(4);  chk("single clap c4", clap_out, 1'b1);
        wait_to(5);  chk("single clap c5", clap_out, 1'b0);
        wait_to(14); chk("single busy c14", busy, 1'b1);
                     chk("single done c14", done, 1'b0);
        wait_to(15); chk("single done c15", done, 1'b1);
                     chk("single ready c15", ready, 1'b1);
        wait_to(16); chk("single done c16", done, 1'b0);
        wait_to(20);

        // Double clap; num_claps wiggles while busy and must not matter
        launch(1'b1);
        num_claps = 1'b0;
        wait_to(4);  chk("double clap c4", clap_out, 1'b1);
        wait_to(5);  chk("double clap c5", clap_out, 1'b0);
        num_claps = 1'b1;
        wait_to(10); chk("double clap c10", clap_out, 1'b0);
        wait_to(11); chk("double clap c11", clap_out, 1'b1);
        num_claps = 1'b0;
        wait_to(14); chk("double clap c14", clap_out, 1'b1);
        wait_to(15); chk("double clap c15", clap_out, 1'b0);
        wait_to(24); chk("double done c24", done, 1'b0);
        wait_to(25); chk("double done c25", done, 1'b1);
        wait_to(30);

        // Starts while busy are ignored
        launch(1'b0);
        wait_to(3);  start = 1'b1; num_claps = 1'b1;
        wait_to(4);  start = 1'b0;
        wait_to(12); start = 1'b1;
        wait_to(13); start = 1'b0; num_claps = 1'b0;
        wait_to(15); chk("ignored done c15", done, 1'b1);
        wait_to(16); chk("ignored clap c16", clap_out, 1'b0);
                     chk("ignored ready c16", ready, 1'b1);
        wait_to(20);

        // Reset in the middle of the second clap
        launch(1'b1);
        wait_to(12); rst_n = 1'b0;
        wait_to(13); chk("abort clap c13", clap_out, 1'b0);
                     chk("abort ready c13", ready, 1'b1);
        rst_n = 1'b1;
        wait_to(25); chk("abort done c25", done, 1'b0);
        wait_to(40);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1; num_claps = 1'b0; k = cyc;
        wait_to(15); chk("b2b done c15", done, 1'b1);
        wait_to(16); chk("b2b clap c16", clap_out, 1'b1);
        wait_to(19); chk("b2b clap c19", clap_out, 1'b1);
        wait_to(20); chk("b2b clap c20", clap_out, 1'b0);
        wait_to(30); chk("b2b done c30", done, 1'b1);
        wait_to(31); chk("b2b clap c31", clap_out, 1'b1);
        wait_to(34); chk("b2b clap c34", clap_out, 1'b1);
        start = 1'b0;
        wait_to(35); chk("b2b clap c35", clap_out, 1'b0);
        wait_to(50);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
